// File: rtl/npc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// npc_ctrl_pkg
// Shared definitions for the fetch-side next-PC controller.
//   NPC_AW        default PC width
//   NPC_RESET_PC  default fetch address loaded on reset
//   npc_state_e   controller state: RUN (no redirect buffered) / HOLD (buffered)
//   npc_misaligned() helper: true when a word target has nonzero low bits
// -----------------------------------------------------------------------------
package npc_ctrl_pkg;

   localparam int          NPC_AW       = 32;
   localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } npc_state_e;

   function automatic logic npc_misaligned(input logic [1:0] low_bits);
      return |low_bits;
   endfunction

endpackage

// File: rtl/npc_ctrl_if.sv
// -----------------------------------------------------------------------------
// npc_ctrl_if
// Groups the ID-stage control-transfer requests, the hazard/fetch handshake
// and the fetch-PC outputs of npc_ctrl.
//   master : drives stall/if_wait and the br/j/jr requests, observes pc/status
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface npc_ctrl_if #(
   parameter int AW = 32
);
   logic          stall;
   logic          if_wait;
   logic          br_req;
   logic          br_taken;
   logic [15:0]   br_imm;
   logic          j_req;
   logic [25:0]   j_idx;
   logic          jr_req;
   logic [AW-1:0] jr_tgt;
   logic [AW-1:0] id_pc4;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc4;
   logic          redir_ack;
   logic          pend;
   logic          ctl_err;

   modport master (
      output stall, if_wait, br_req, br_taken, br_imm, j_req, j_idx,
             jr_req, jr_tgt, id_pc4,
      input  pc, pc4, redir_ack, pend, ctl_err
   );

   modport slave (
      input  stall, if_wait, br_req, br_taken, br_imm, j_req, j_idx,
             jr_req, jr_tgt, id_pc4,
      output pc, pc4, redir_ack, pend, ctl_err
   );
endinterface

// File: rtl/npc_ctrl_tgt.sv
// -----------------------------------------------------------------------------
// npc_ctrl_tgt
// Combinational redirect target unit: computes the branch / jump / register
// targets, selects one with priority jr > j > br, and flags conflicts.
//   br_req, br_taken, br_imm : conditional branch request, result, offset
//   j_req, j_idx             : j/jal request and index field
//   jr_req, jr_tgt           : jr/jalr request and forwarded rs
//   id_pc4                   : PC+4 of the ID instruction
//   redir      : a control transfer is requested this cycle
//   multi      : more than one transfer requested at once
//   misaligned : selected target has nonzero low bits
//   target     : selected target address (modulo 2^AW)
// -----------------------------------------------------------------------------
module npc_ctrl_tgt
   import npc_ctrl_pkg::*;
#(
   parameter int AW = NPC_AW
) (
   input  logic          br_req,
   input  logic          br_taken,
   input  logic [15:0]   br_imm,
   input  logic          j_req,
   input  logic [25:0]   j_idx,
   input  logic          jr_req,
   input  logic [AW-1:0] jr_tgt,
   input  logic [AW-1:0] id_pc4,
   output logic          redir,
   output logic          multi,
   output logic          misaligned,
   output logic [AW-1:0] target
);

   logic          br_hit;
   logic [AW-1:0] br_off;
   logic [AW-1:0] br_tgt;
   logic [AW-1:0] j_tgt;

   // An untaken branch is ordinary sequential flow, not a redirect.
   assign br_hit = br_req & br_taken;

   // Sign-extended word offset; the adder wraps naturally at AW bits.
   assign br_off = {{(AW-18){br_imm[15]}}, br_imm, 2'b00};
   assign br_tgt = id_pc4 + br_off;

   // Jumps stay inside the 256 MB region of the delay-slot address.
   assign j_tgt  = {id_pc4[AW-1:28], j_idx, 2'b00};

   always_comb begin
      target = br_tgt;
      if (jr_req) begin
         target = jr_tgt;
      end else if (j_req) begin
         target = j_tgt;
      end
   end

   assign redir      = br_hit | j_req | jr_req;
   assign multi      = (br_hit & j_req) | (br_hit & jr_req) | (j_req & jr_req);
   assign misaligned = npc_misaligned(target[1:0]);

endmodule

// File: rtl/npc_ctrl.sv
// -----------------------------------------------------------------------------
// npc_ctrl
// Fetch-side next-PC controller. Owns the fetch PC, applies ID-stage
// branch/jump redirects with a one-instruction delay slot, freezes on hazard
// stalls, and buffers a redirect while the delay-slot fetch is outstanding.
//   clk    : system clock
//   reset  : asynchronous, active-high
//   bus    : npc_ctrl_if slave (requests in; pc, pc4, redir_ack, pend,
//            ctl_err out)
// -----------------------------------------------------------------------------
module npc_ctrl
   import npc_ctrl_pkg::*;
#(
   parameter int          AW       = NPC_AW,
   parameter logic [AW-1:0] RESET_PC = AW'(NPC_RESET_PC)
) (
   input  logic       clk,
   input  logic       reset,
   npc_ctrl_if.slave  bus
);

   localparam logic [AW-1:0] PC_STEP = AW'(4);

   npc_state_e    state_reg, state_next;
   logic [AW-1:0] pc_reg, pc_next;
   logic [AW-1:0] pend_tgt_reg, pend_tgt_next;
   logic          ack_reg, ack_next;
   logic          err_reg, err_next;

   logic          redir;
   logic          multi;
   logic          misaligned;
   logic [AW-1:0] target;

   npc_ctrl_tgt #(
      .AW (AW)
   ) u_tgt (
      .br_req     (bus.br_req),
      .br_taken   (bus.br_taken),
      .br_imm     (bus.br_imm),
      .j_req      (bus.j_req),
      .j_idx      (bus.j_idx),
      .jr_req     (bus.jr_req),
      .jr_tgt     (bus.jr_tgt),
      .id_pc4     (bus.id_pc4),
      .redir      (redir),
      .multi      (multi),
      .misaligned (misaligned),
      .target     (target)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= RUN;
         pc_reg       <= RESET_PC;
         pend_tgt_reg <= '0;
         ack_reg      <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         pend_tgt_reg <= pend_tgt_next;
         ack_reg      <= ack_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      pend_tgt_next = pend_tgt_reg;
      ack_next      = 1'b0;
      err_next      = err_reg;

      // A stalled ID re-presents its request next cycle, so nothing is
      // accepted or flagged while frozen; stall also outranks if_wait.
      if (!bus.stall) begin
         unique case (state_reg)
            RUN: begin
               if (redir) begin
                  ack_next = 1'b1;
                  // A misaligned target is still taken so the exception
                  // path sees the faulting address.
                  if (multi || misaligned) begin
                     err_next = 1'b1;
                  end
                  if (bus.if_wait) begin
                     // Delay slot not yet fetched: park the target.
                     pend_tgt_next = target;
                     state_next    = HOLD;
                  end else begin
                     pc_next = target;
                  end
               end else if (!bus.if_wait) begin
                  pc_next = pc_reg + PC_STEP;
               end
            end
            HOLD: begin
               // The only instruction ID can hold here is the delay slot,
               // and a transfer there is illegal; it is dropped, not queued.
               if (redir) begin
                  err_next = 1'b1;
               end
               if (!bus.if_wait) begin
                  pc_next    = pend_tgt_reg;
                  state_next = RUN;
               end
            end
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

   assign bus.pc        = pc_reg;
   assign bus.pc4       = pc_reg + PC_STEP;
   assign bus.redir_ack = ack_reg;
   assign bus.pend      = (state_reg == HOLD);
   assign bus.ctl_err   = err_reg;

endmodule

// File: tb/tb_npc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_npc_ctrl
// Scoreboard bench for npc_ctrl: the driver applies stimulus at the falling
// edge, computes the expected post-edge state from a behavioural model and
// queues it; the monitor pops and compares just after every rising edge.
// -----------------------------------------------------------------------------
module tb_npc_ctrl;
   import npc_ctrl_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   typedef struct {
      logic [31:0] pc;
      logic        pend;
      logic        ack;
      logic        err;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   npc_ctrl_if #(.AW(32)) bus ();

   npc_ctrl #(
      .AW       (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t        exp_q[$];
   exp_t        got;
   int          n_chk  = 0;
   int          n_pass = 0;
   bit          started = 1'b0;

   // Reference state, kept as plain architectural quantities.
   logic [31:0] m_pc   = RST_PC;
   logic [31:0] m_tgt  = '0;
   bit          m_pend = 1'b0;
   bit          m_ack  = 1'b0;
   bit          m_err  = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endfunction

   // Expected state after the coming rising edge.
   function automatic void model_step(input bit rst_at_edge);
      int          nreq;
      bit          want;
      logic [31:0] tgt;
      if (rst_at_edge) begin
         m_pc = RST_PC; m_pend = 0; m_tgt = '0; m_ack = 0; m_err = 0;
         return;
      end
      nreq = int'(bus.br_req && bus.br_taken) + int'(bus.j_req) + int'(bus.jr_req);
      want = (nreq > 0);
      if (bus.jr_req)      tgt = bus.jr_tgt;
      else if (bus.j_req)  tgt = (bus.id_pc4 & 32'hF000_0000) | (32'(bus.j_idx) * 4);
      else                 tgt = bus.id_pc4 + 32'(int'($signed(bus.br_imm)) * 4);
      m_ack = 0;
      if (bus.stall) return;
      if (!m_pend) begin
         if (want) begin
            m_ack = 1;
            if (nreq > 1 || (tgt % 4) != 0) m_err = 1;
            if (bus.if_wait) begin m_pend = 1; m_tgt = tgt; end
            else m_pc = tgt;
         end else if (!bus.if_wait) begin
            m_pc = m_pc + 4;
         end
      end else begin
         if (want) m_err = 1;
         if (!bus.if_wait) begin m_pc = m_tgt; m_pend = 0; end
      end
   endfunction

   task automatic clr();
      bus.stall = 0; bus.if_wait = 0; bus.br_req = 0; bus.br_taken = 0;
      bus.br_imm = '0; bus.j_req = 0; bus.j_idx = '0; bus.jr_req = 0;
      bus.jr_tgt = '0; bus.id_pc4 = '0;
   endtask

   // One cycle of stimulus; inputs are already driven. async_r pulses reset
   // between edges and checks that it acts without a clock.
   task automatic tick(input bit async_r);
      exp_t e;
      model_step(reset || async_r);
      e.pc = m_pc; e.pend = m_pend; e.ack = m_ack; e.err = m_err;
      exp_q.push_back(e);
      started = 1'b1;
      if (async_r) begin
         #2 reset = 1'b1;
         #1;
         chk("async_reset_pc", bus.pc, RST_PC);
         chk("async_reset_pend", 32'(bus.pend), 32'd0);
      end
      @(negedge clk);
   endtask

   // Monitor: the DUT presents a new state every rising edge.
   always @(posedge clk) begin
      #1;
      if (started) begin
         if (exp_q.size() == 0) begin
            chk("queue_underrun", 32'd1, 32'd0);
         end else begin
            got = exp_q.pop_front();
            chk("pc", bus.pc, got.pc);
            chk("pc4", bus.pc4, got.pc + 32'd4);
            chk("pend", 32'(bus.pend), 32'(got.pend));
            chk("redir_ack", 32'(bus.redir_ack), 32'(got.ack));
            chk("ctl_err", 32'(bus.ctl_err), 32'(got.err));
            if (bus.redir_ack)
               $display("redirect accepted: pc=%h pend=%0b ctl_err=%0b", bus.pc, bus.pend, bus.ctl_err);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      clr();
      reset = 1'b1;
      @(negedge clk);
      tick(0); tick(0);
      reset = 1'b0;

      // Sequential fetch from reset.
      repeat (3) tick(0);

      // Taken branch backwards by two words, then an untaken branch.
      bus.id_pc4 = 32'h3008; bus.br_imm = 16'hFFFE; bus.br_req = 1; bus.br_taken = 1;
      tick(0);
      bus.br_taken = 0;
      tick(0);
      clr();

      // Jump held off by a two-cycle stall.
      bus.j_req = 1; bus.j_idx = 26'h0000C10; bus.id_pc4 = 32'h3010; bus.stall = 1;
      tick(0); tick(0);
      bus.stall = 0;
      tick(0);
      clr();
      tick(0);

      // jr accepted while fetch waits, released three cycles later.
      bus.jr_req = 1; bus.jr_tgt = 32'h4000; bus.if_wait = 1;
      tick(0);
      bus.jr_req = 0;
      tick(0); tick(0);
      bus.if_wait = 0;
      tick(0);
      tick(0);

      // Illegal taken branch in the delay slot while a target is buffered.
      bus.jr_req = 1; bus.jr_tgt = 32'h5000; bus.if_wait = 1;
      tick(0);
      bus.jr_req = 0; bus.br_req = 1; bus.br_taken = 1; bus.id_pc4 = 32'h3100; bus.br_imm = 16'h0010;
      tick(0);
      clr();
      tick(0);

      // Misaligned register target.
      reset = 1'b1; tick(0); reset = 1'b0;
      bus.jr_req = 1; bus.jr_tgt = 32'h4002;
      tick(0);
      clr();
      tick(0);

      // Release and a new request in the same cycle.
      reset = 1'b1; tick(0); reset = 1'b0;
      bus.j_req = 1; bus.j_idx = 26'h0000800; bus.id_pc4 = 32'h3004; bus.if_wait = 1;
      tick(0);
      bus.j_req = 0; bus.if_wait = 0; bus.jr_req = 1; bus.jr_tgt = 32'h6000;
      tick(0);
      clr();
      tick(0);

      // Asynchronous reset while a redirect is buffered.
      reset = 1'b1; tick(0); reset = 1'b0;
      bus.jr_req = 1; bus.jr_tgt = 32'h4000; bus.if_wait = 1;
      tick(0);
      clr(); bus.if_wait = 1;
      tick(1);
      reset = 1'b0; bus.if_wait = 0;
      tick(0);
      tick(0);

      // Randomized traffic with periodic resets to re-arm ctl_err.
      for (int i = 0; i < 400; i++) begin
         clr();
         reset = (i % 50 == 0);
         bus.stall   = ($urandom_range(0, 4) == 0);
         bus.if_wait = ($urandom_range(0, 9) < 3);
         bus.id_pc4  = $urandom() & 32'hFFFF_FFFC;
         bus.br_imm  = 16'($urandom());
         bus.j_idx   = 26'($urandom());
         bus.jr_tgt  = $urandom();
         if ($urandom_range(0, 7) != 0) bus.jr_tgt = bus.jr_tgt & 32'hFFFF_FFFC;
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1: begin bus.br_req = 1; bus.br_taken = 1; end
            2:    begin bus.br_req = 1; bus.br_taken = 0; end
            3:    bus.j_req = 1;
            4:    bus.jr_req = 1;
            5:    begin bus.j_req = 1; bus.br_req = 1; bus.br_taken = 1; end
            6:    begin bus.jr_req = 1; bus.j_req = 1; end
            default: ;
         endcase
         tick(0);
      end
      clr();
      reset = 1'b0;
      tick(0);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
